// File: rtl/rx_tl_pkg.sv
// -----------------------------------------------------------------------------
// rx_tl_pkg
// Shared types and constants for the RX transaction-layer TLP arbiter.
//   arb_state_t : arbiter FSM states
//   SRC_P/SRC_NP: encoding of the source class carried with each output beat
//   *_DEF       : default parameter values for the arbiter
// -----------------------------------------------------------------------------
package rx_tl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_P  = 2'd1,
        SERVE_NP = 2'd2
    } arb_state_t;

    localparam logic SRC_P  = 1'b0;
    localparam logic SRC_NP = 1'b1;

    localparam int DATA_W_DEF    = 1024;
    localparam int P_WEIGHT_DEF  = 3;
    localparam int NP_WEIGHT_DEF = 1;
    localparam int CNT_W_DEF     = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_tl_out_slice.sv
// -----------------------------------------------------------------------------
// rx_tl_out_slice
// One-stage registered valid/ready output slice for the TLP arbiter.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   arb_enable          : when low no new beat may be loaded
//   load                : load in_data/in_src this cycle (only while load_en)
//   in_data, in_src     : beat selected by the arbiter
//   load_en             : slot free or being emptied this cycle, and enabled
//   out_data/out_valid/out_src : registered beat towards the de-packetizer
//   out_ready           : sink accepts the beat
// -----------------------------------------------------------------------------
module rx_tl_out_slice
    import rx_tl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arb_enable,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_src,
    output logic              load_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_src,
    input  logic              out_ready
);

    // A new beat may enter when the register is empty or is being drained
    // in the same cycle, which sustains one beat per clock.
    assign load_en = arb_enable && (!out_valid || out_ready);

    // Output register stage: load wins; otherwise an accepted beat empties
    // the slot. Data and src only change on a load, so they hold under
    // backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_P;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_src   <= in_src;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_tlp_arbiter.sv
// -----------------------------------------------------------------------------
// rx_tlp_arbiter
// Weighted round-robin arbiter between the posted (P) and non-posted /
// completion (NP) RX TLP queues, feeding the de-packetizer through a
// registered valid/ready stage, with saturating per-class grant counters.
// Ports:
//   clk, reset                         : clock, async active-high reset
//   p_tlp_data/valid/ready             : P queue head and pop strobe
//   np_tlp_data/valid/ready            : NP queue head and pop strobe
//   arb_enable                         : 0 stops new grants, output drains
//   tlp_out_data/valid/src, tlp_out_ready : registered output beat
//   cnt_clr                            : synchronous clear of grant counters
//   p_grant_cnt, np_grant_cnt          : saturating grant counts
// -----------------------------------------------------------------------------
module rx_tlp_arbiter
    import rx_tl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int P_WEIGHT  = P_WEIGHT_DEF,
    parameter int NP_WEIGHT = NP_WEIGHT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] p_tlp_data,
    input  logic              p_tlp_valid,
    output logic              p_tlp_ready,
    input  logic [DATA_W-1:0] np_tlp_data,
    input  logic              np_tlp_valid,
    output logic              np_tlp_ready,
    input  logic              arb_enable,
    output logic [DATA_W-1:0] tlp_out_data,
    output logic              tlp_out_valid,
    output logic              tlp_out_src,
    input  logic              tlp_out_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  p_grant_cnt,
    output logic [CNT_W-1:0]  np_grant_cnt
);

    localparam int MAX_W = max_int(P_WEIGHT, NP_WEIGHT);
    localparam int BW    = $clog2(MAX_W + 1);

    localparam logic [BW-1:0] ONE  = BW'(1);
    localparam logic [BW-1:0] P_W  = BW'(P_WEIGHT);
    localparam logic [BW-1:0] NP_W = BW'(NP_WEIGHT);

    arb_state_t    state, state_nxt;
    logic [BW-1:0] burst_cnt, burst_nxt;
    logic          last_class, last_nxt;
    logic          sel_p, sel_np;
    logic          load_en;

    // Grant selection: combinational from state, burst count and valids,
    // gated by load_en so a pop only happens when the beat is taken.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        last_nxt  = last_class;
        sel_p     = 1'b0;
        sel_np    = 1'b0;
        if (load_en) begin
            case (state)
                IDLE: begin
                    // On a tie the class not served last goes first.
                    if (p_tlp_valid && (!np_tlp_valid || last_class == SRC_NP)) begin
                        sel_p     = 1'b1;
                        state_nxt = SERVE_P;
                        burst_nxt = ONE;
                    end else if (np_tlp_valid) begin
                        sel_np    = 1'b1;
                        state_nxt = SERVE_NP;
                        burst_nxt = ONE;
                    end
                end
                SERVE_P: begin
                    if (p_tlp_valid && burst_cnt < P_W) begin
                        sel_p     = 1'b1;
                        burst_nxt = burst_cnt + ONE;
                    end else if (np_tlp_valid) begin
                        sel_np    = 1'b1;
                        state_nxt = SERVE_NP;
                        burst_nxt = ONE;
                        last_nxt  = SRC_P;
                    end else if (p_tlp_valid) begin
                        // Weight used up but nobody competing: restart burst.
                        sel_p     = 1'b1;
                        burst_nxt = ONE;
                    end else begin
                        state_nxt = IDLE;
                        burst_nxt = '0;
                        last_nxt  = SRC_P;
                    end
                end
                SERVE_NP: begin
                    if (np_tlp_valid && burst_cnt < NP_W) begin
                        sel_np    = 1'b1;
                        burst_nxt = burst_cnt + ONE;
                    end else if (p_tlp_valid) begin
                        sel_p     = 1'b1;
                        state_nxt = SERVE_P;
                        burst_nxt = ONE;
                        last_nxt  = SRC_NP;
                    end else if (np_tlp_valid) begin
                        sel_np    = 1'b1;
                        burst_nxt = ONE;
                    end else begin
                        state_nxt = IDLE;
                        burst_nxt = '0;
                        last_nxt  = SRC_NP;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    burst_nxt = '0;
                end
            endcase
        end
    end

    assign p_tlp_ready  = sel_p;
    assign np_tlp_ready = sel_np;

    // Arbiter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_class <= SRC_NP;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_nxt;
            last_class <= last_nxt;
        end
    end

    // Grant statistics; clear takes priority over a same-cycle grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_grant_cnt  <= '0;
            np_grant_cnt <= '0;
        end else if (cnt_clr) begin
            p_grant_cnt  <= '0;
            np_grant_cnt <= '0;
        end else begin
            if (sel_p && p_grant_cnt != '1)
                p_grant_cnt <= p_grant_cnt + CNT_W'(1);
            if (sel_np && np_grant_cnt != '1)
                np_grant_cnt <= np_grant_cnt + CNT_W'(1);
        end
    end

    rx_tl_out_slice #(
        .DATA_W (DATA_W)
    ) u_out_slice (
        .clk        (clk),
        .reset      (reset),
        .arb_enable (arb_enable),
        .load       (sel_p | sel_np),
        .in_data    (sel_np ? np_tlp_data : p_tlp_data),
        .in_src     (sel_np ? SRC_NP : SRC_P),
        .load_en    (load_en),
        .out_data   (tlp_out_data),
        .out_valid  (tlp_out_valid),
        .out_src    (tlp_out_src),
        .out_ready  (tlp_out_ready)
    );

endmodule

// File: tb/tb_rx_tlp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rx_tlp_arbiter
// Self-checking bench for rx_tlp_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural model of the arbiter.
// -----------------------------------------------------------------------------
module tb_rx_tlp_arbiter;

    localparam int DW  = 64;
    localparam int PW  = 3;
    localparam int NPW = 1;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam logic [DW-1:0] A5 = 64'hA5A5_A5A5_A5A5_A5A5;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] p_tlp_data, np_tlp_data;
    logic          p_tlp_valid, np_tlp_valid;
    logic          p_tlp_ready, np_tlp_ready;
    logic          arb_enable;
    logic [DW-1:0] tlp_out_data;
    logic          tlp_out_valid, tlp_out_src, tlp_out_ready;
    logic          cnt_clr;
    logic [CW-1:0] p_grant_cnt, np_grant_cnt;

    rx_tlp_arbiter #(
        .DATA_W    (DW),
        .P_WEIGHT  (PW),
        .NP_WEIGHT (NPW),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p_tlp_data    (p_tlp_data),
        .p_tlp_valid   (p_tlp_valid),
        .p_tlp_ready   (p_tlp_ready),
        .np_tlp_data   (np_tlp_data),
        .np_tlp_valid  (np_tlp_valid),
        .np_tlp_ready  (np_tlp_ready),
        .arb_enable    (arb_enable),
        .tlp_out_data  (tlp_out_data),
        .tlp_out_valid (tlp_out_valid),
        .tlp_out_src   (tlp_out_src),
        .tlp_out_ready (tlp_out_ready),
        .cnt_clr       (cnt_clr),
        .p_grant_cnt   (p_grant_cnt),
        .np_grant_cnt  (np_grant_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_cur: class of the ongoing run (-1 none, 0 P, 1 NP); m_run: its length;
    // m_last: class whose run ended most recently.
    int            m_cur, m_run, m_last;
    bit            m_valid;
    logic [DW-1:0] m_data;
    logic          m_src;
    int            m_pc, m_npc;

    function automatic int weight(input int c);
        return (c == 0) ? PW : NPW;
    endfunction

    function automatic bit model_load();
        return arb_enable && (!m_valid || tlp_out_ready);
    endfunction

    // Which class wins this cycle: -1 none, 0 P, 1 NP.
    function automatic int model_winner();
        if (!model_load()) return -1;
        if (p_tlp_valid && np_tlp_valid) begin
            if (m_cur < 0) return (m_last == 1) ? 0 : 1;
            return (m_run < weight(m_cur)) ? m_cur : 1 - m_cur;
        end
        if (p_tlp_valid)  return 0;
        if (np_tlp_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cur = -1; m_run = 0; m_last = 1;
            m_valid = 1'b0; m_data = '0; m_src = 1'b0;
            m_pc = 0; m_npc = 0;
        end else begin
            int w;
            bit ld;
            w  = model_winner();
            ld = model_load();
            if (cnt_clr) begin
                m_pc = 0; m_npc = 0;
            end else begin
                if (w == 0 && m_pc  < CNT_MAX) m_pc++;
                if (w == 1 && m_npc < CNT_MAX) m_npc++;
            end
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = (w == 0) ? p_tlp_data : np_tlp_data;
                m_src   = (w == 1);
            end else if (tlp_out_ready) begin
                m_valid = 1'b0;
            end
            if (ld) begin
                if (w < 0) begin
                    if (m_cur >= 0) m_last = m_cur;
                    m_cur = -1;
                end else if (w == m_cur) begin
                    m_run = (m_run < weight(m_cur)) ? m_run + 1 : 1;
                end else begin
                    if (m_cur >= 0) m_last = m_cur;
                    m_cur = w;
                    m_run = 1;
                end
            end
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            int w;
            w = model_winner();
            chk("p_ready",   p_tlp_ready,   w == 0);
            chk("np_ready",  np_tlp_ready,  w == 1);
            chk("out_valid", tlp_out_valid, m_valid);
            if (m_valid) begin
                chk("out_data", tlp_out_data, m_data);
                chk("out_src",  tlp_out_src,  m_src);
            end
            chk("p_cnt",  p_grant_cnt,  m_pc);
            chk("np_cnt", np_grant_cnt, m_npc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic sync_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] held;
        reset = 1'b1;
        p_tlp_data = '0; np_tlp_data = '0;
        p_tlp_valid = 1'b0; np_tlp_valid = 1'b0;
        arb_enable = 1'b1; tlp_out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_valid", tlp_out_valid, 0);
        chk("rst_data",  tlp_out_data,  0);
        chk("rst_src",   tlp_out_src,   0);
        chk("rst_pcnt",  p_grant_cnt,   0);
        chk("rst_npcnt", np_grant_cnt,  0);

        // Single P beat.
        @(posedge clk); #1;
        p_tlp_valid = 1'b1; p_tlp_data = A5;
        #1 chk("single_p_ready", p_tlp_ready, 1);
        @(posedge clk); #1;
        p_tlp_valid = 1'b0;
        chk("single_valid", tlp_out_valid, 1);
        chk("single_src",   tlp_out_src,   0);
        chk("single_data",  tlp_out_data,  A5);
        chk("single_pcnt",  p_grant_cnt,   1);
        @(posedge clk); #1;
        chk("single_drain", tlp_out_valid, 0);

        // Weighted ratio P,P,P,NP.
        sync_reset();
        p_tlp_valid = 1'b1; np_tlp_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p_tlp_data = {$urandom, $urandom}; np_tlp_data = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("wrr_src", tlp_out_src, (i % 4) == 3);
        end
        p_tlp_valid = 1'b0; np_tlp_valid = 1'b0;
        chk("wrr_pcnt",  p_grant_cnt,  12);
        chk("wrr_npcnt", np_grant_cnt, 4);
        @(posedge clk); #1;

        // Backpressure with a held beat.
        p_tlp_valid = 1'b1; p_tlp_data = {$urandom, $urandom};
        @(posedge clk); #1;
        tlp_out_ready = 1'b0; np_tlp_valid = 1'b1;
        np_tlp_data = {$urandom, $urandom}; p_tlp_data = {$urandom, $urandom};
        held = tlp_out_data;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_data",  tlp_out_data, held);
            chk("bp_ready", {p_tlp_ready, np_tlp_ready}, 0);
        end
        tlp_out_ready = 1'b1;
        #1 chk("bp_reload", p_tlp_ready | np_tlp_ready, 1);
        @(posedge clk); #1;
        chk("bp_valid", tlp_out_valid, 1);
        p_tlp_valid = 1'b0; np_tlp_valid = 1'b0;
        @(posedge clk); #1;

        // Lone NP class, four back-to-back grants.
        sync_reset();
        np_tlp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            np_tlp_data = {$urandom, $urandom};
            #1 chk("lone_np_ready", {p_tlp_ready, np_tlp_ready}, 1);
            @(posedge clk); #1;
        end
        np_tlp_valid = 1'b0;
        chk("lone_npcnt", np_grant_cnt, 4);
        chk("lone_src",   tlp_out_src,  1);

        // Enable off mid-burst, then clear together with a grant.
        p_tlp_valid = 1'b1; np_tlp_valid = 1'b1;
        @(posedge clk); #1;
        arb_enable = 1'b0;
        #1 chk("dis_ready", {p_tlp_ready, np_tlp_ready}, 0);
        @(posedge clk); #1;
        chk("dis_drain", tlp_out_valid, 0);
        @(posedge clk); #1;
        arb_enable = 1'b1; cnt_clr = 1'b1;
        #1 chk("clr_grant", p_tlp_ready | np_tlp_ready, 1);
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_pcnt",  p_grant_cnt,  0);
        chk("clr_npcnt", np_grant_cnt, 0);
        p_tlp_valid = 1'b0; np_tlp_valid = 1'b0;
        @(posedge clk); #1;

        // Counter saturation.
        sync_reset();
        p_tlp_valid = 1'b1;
        repeat (CNT_MAX + 5) @(posedge clk);
        #1 chk("sat_pcnt", p_grant_cnt, CNT_MAX);
        p_tlp_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            p_tlp_valid   = ($urandom % 4) != 0;
            np_tlp_valid  = ($urandom % 3) != 0;
            p_tlp_data    = {$urandom, $urandom};
            np_tlp_data   = {$urandom, $urandom};
            tlp_out_ready = ($urandom % 4) != 0;
            arb_enable    = ($urandom % 16) != 0;
            cnt_clr       = ($urandom % 64) == 0;
            @(posedge clk); #1;
        end
        arb_enable = 1'b1; cnt_clr = 1'b0;

        // Asynchronous reset while a beat is held.
        p_tlp_valid = 1'b1; np_tlp_valid = 1'b1; tlp_out_ready = 1'b0;
        @(posedge clk); #3;
        chk("pre_rst_valid", tlp_out_valid, 1);
        reset = 1'b1;
        #1;
        chk("arst_valid", tlp_out_valid, 0);
        chk("arst_data",  tlp_out_data,  0);
        chk("arst_pcnt",  p_grant_cnt,   0);
        chk("arst_npcnt", np_grant_cnt,  0);
        @(posedge clk); #3;
        reset = 1'b0; tlp_out_ready = 1'b1;
        #1 chk("arst_first_p", {p_tlp_ready, np_tlp_ready}, 2'b10);
        @(posedge clk); #1;
        chk("arst_first_src", tlp_out_src, 0);
        p_tlp_valid = 1'b0; np_tlp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rx_tlp_arbiter.md
Name: rx_tlp_arbiter

Overview:
- Weighted round-robin arbiter between the two RX transaction-layer TLP queues: posted (P) and non-posted/completion (NP).
- Sits between the two per-class FIFOs and the de-packetizer.
- Picks one head TLP per cycle and presents it through a one-stage registered output with a valid/ready handshake.
- Keeps saturating per-class grant counters for software visibility.

Parameters:
- DATA_W, 1024, TLP beat width (one TLP per beat)
- P_WEIGHT, 3, maximum consecutive P grants while NP is waiting (≥1)
- NP_WEIGHT, 1, maximum consecutive NP grants while P is waiting (≥1)
- CNT_W, 16, width of the grant statistic counters

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  asynchronous, active-high reset
- p_tlp_data  in  DATA_W  P queue head TLP
- p_tlp_valid  in  1  P queue head valid
- p_tlp_ready  out  1  P head consumed this cycle (FIFO pop)
- np_tlp_data  in  DATA_W  NP queue head TLP
- np_tlp_valid  in  1  NP queue head valid
- np_tlp_ready  out  1  NP head consumed this cycle
- arb_enable  in  1  0 = no new grants; the output register still drains
- tlp_out_data  out  DATA_W  registered selected TLP
- tlp_out_valid  out  1  output beat valid
- tlp_out_src  out  1  source class of the output beat: 0 = P, 1 = NP
- tlp_out_ready  in  1  de-packetizer accepts the beat
- cnt_clr  in  1  synchronous clear of both grant counters
- p_grant_cnt  out  CNT_W  saturating count of P grants
- np_grant_cnt  out  CNT_W  saturating count of NP grants

Behaviour:
- Reset (async, active-high) values:
  - all outputs 0, including tlp_out_data;
  - state = IDLE; burst_cnt = 0; last_class = NP, so P wins the first tie.
- Any in-flight output beat is discarded on reset.
- load_en = arb_enable && (!tlp_out_valid || tlp_out_ready). This gives full throughput: 1 beat/cycle when the sink is always ready.
- Grant (selection) is combinational from the state, burst_cnt and the two valids. The chosen ready is asserted only when load_en=1.
  - At most one of p_tlp_ready / np_tlp_ready is high in any cycle.
  - A ready is never high while its own valid is low.
- On a grant: tlp_out_data, tlp_out_src and tlp_out_valid are registered next edge. Latency from input handshake to output valid is 1 cycle.
- Output beat handling:
  - If tlp_out_valid && tlp_out_ready && !load_en: tlp_out_valid clears.
  - While tlp_out_valid && !tlp_out_ready: data and src are held stable.
- FSM states: IDLE, SERVE_P, SERVE_NP.
- IDLE:
  - Only P valid → grant P, go to SERVE_P, burst_cnt = 1.
  - Only NP valid → grant NP, go to SERVE_NP, burst_cnt = 1.
  - Both valid → grant the class != last_class.
- SERVE_X (W = weight of X, Y = the other class), evaluated only when load_en:
  - X valid and burst_cnt < W → grant X, burst_cnt++.
  - Otherwise, if Y valid → grant Y, go to SERVE_Y, burst_cnt = 1, last_class = X.
  - Otherwise, if X valid (weight exhausted, no competitor) → grant X, burst_cnt = 1.
  - Otherwise → IDLE, last_class = X.
- When load_en = 0: state, burst_cnt and last_class hold.
- burst_cnt width = clog2(max weight + 1); it never exceeds max(P_WEIGHT, NP_WEIGHT).
- Counters: increment on each granted beat of their class and saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle; the counter reads 0 next cycle.
- arb_enable deasserted mid-burst: grants stop immediately and the held output beat still drains. On re-enable, arbitration resumes from the held state.

Decomposition:
- Package rx_tl_pkg holds:
  - arb_state_t enum (IDLE, SERVE_P, SERVE_NP);
  - SRC_P = 1'b0, SRC_NP = 1'b1;
  - default weight constants.
- Natural sub-module: rx_tl_out_slice, the registered valid/ready output stage (data + src, load_en generation). The arbiter FSM and counters stay in the top module.

Test Plan:
- Single beat: reset, P valid with data 0xA5…, NP idle, sink ready → p_tlp_ready pulses once; next cycle tlp_out_valid=1, src=0, data 0xA5…; p_grant_cnt=1.
- Weighted ratio: both queues valid for 16 cycles, sink always ready, default weights → src sequence P,P,P,NP repeating; p_grant_cnt=12, np_grant_cnt=4.
- Backpressure: tlp_out_ready=0 for 5 cycles with a beat held → data/src stable, both input readies 0; ready=1 → beat accepted and the next grant loads in the same cycle.
- Lone class: only NP valid for 4 beats (NP_WEIGHT=1) → 4 consecutive NP grants with no idle cycles and no P ready.
- Enable/clear: arb_enable=0 mid-burst → no readies while the output drains. cnt_clr together with a grant → counters read 0 next cycle.
- Reset mid-operation: assert reset while tlp_out_valid=1 → tlp_out_valid drops asynchronously and counters are 0. After release, both queues valid → P granted first.
